// File: rtl/debounce_multi.sv
// Multi-channel key debouncer with press/release pulses, long-press detection
// and optional auto-repeat. Each channel is an independent slice.
module debounce_multi #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] i_key,
    input  logic [N_CH-1:0] i_repeat_en,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long
);

    localparam int unsigned STAB_W   = $clog2(STABLE_CYCLES) + 1;
    localparam int unsigned HOLD_MAX = LONG_CYCLES + REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX) + 1;
    localparam logic        IDLE_RAW = ACTIVE_LOW;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic              sync_q1;
        logic              sync_q2;
        logic              sync_p;
        logic [STAB_W-1:0] stab_q;
        logic [STAB_W-1:0] stab_d;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic              level_q;
        logic              level_d;
        logic              press_q;
        logic              press_d;
        logic              release_q;
        logic              release_d;
        logic              long_q;
        logic              long_d;

        // Polarity-normalised synchronised key, 1 = pressed
        assign sync_p = sync_q2 ^ ACTIVE_LOW;

        // Two-flop synchroniser, resets to the idle raw level
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync_q1 <= IDLE_RAW;
                sync_q2 <= IDLE_RAW;
            end else begin
                sync_q1 <= i_key[ch];
                sync_q2 <= sync_q1;
            end
        end

        // Debounce, hold timing and event generation for this channel
        always_comb begin
            stab_d    = '0;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
            hold_d    = '0;

            if (sync_p != level_q) begin
                if (stab_q == STAB_W'(STABLE_CYCLES - 1)) begin
                    level_d = sync_p;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end

            if (level_d && !level_q) begin
                press_d = 1'b1;
            end else if (!level_d && level_q) begin
                release_d = 1'b1;
            end else if (level_q) begin
                if (i_repeat_en[ch] && (hold_q >= HOLD_W'(HOLD_MAX - 1))) begin
                    press_d = 1'b1;
                    hold_d  = HOLD_W'(LONG_CYCLES);
                end else begin
                    hold_d = (hold_q < HOLD_W'(HOLD_MAX)) ? hold_q + HOLD_W'(1) : hold_q;
                    long_d = (hold_q == HOLD_W'(LONG_CYCLES - 1));
                end
            end
        end

        // Channel state and registered event outputs
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                stab_q    <= '0;
                hold_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                stab_q    <= stab_d;
                hold_q    <= hold_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        assign o_level[ch]   = level_q;
        assign o_press[ch]   = press_q;
        assign o_release[ch] = release_q;
        assign o_long[ch]    = long_q;
    end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter N_CH, default 4, is the number of independent key channels (1..32).
REQ-002 Parameter STABLE_CYCLES, default 500000, is the number of consecutive stable synchronised samples required to accept a level change (>=2).
REQ-003 Parameter LONG_CYCLES, default 50000000, is the number of debounced-held cycles before a long-press event (> STABLE_CYCLES).
REQ-004 Parameter REPEAT_CYCLES, default 10000000, is the auto-repeat period after a long press (>=2).
REQ-005 Parameter ACTIVE_LOW, default 1: 1 means a raw 0 is "pressed" (DE2-115 KEY); 0 means a raw 1 is "pressed".
REQ-006 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-008 Port i_key, input, N_CH: raw asynchronous key inputs.
REQ-009 Port i_repeat_en, input, N_CH: per-channel auto-repeat enable.
REQ-010 Port o_level, output, N_CH: debounced pressed level, 1 = pressed.
REQ-011 Port o_press, output, N_CH: one-cycle pulse on each accepted press and on each auto-repeat tick.
REQ-012 Port o_release, output, N_CH: one-cycle pulse on each accepted release.
REQ-013 Port o_long, output, N_CH: one-cycle pulse when a hold reaches LONG_CYCLES.

Function
REQ-014 Each channel shall be fully independent; no channel's state shall affect another's.
REQ-015 Each channel shall pass i_key through a 2-flop synchroniser, then normalise polarity per ACTIVE_LOW, giving sync_p (1 = pressed).
REQ-016 Stability counter: increments on each edge where sync_p != o_level; clears to 0 on any edge where sync_p == o_level (a glitch restarts the count).
REQ-017 When the counter reaches STABLE_CYCLES, o_level shall toggle on that edge and the counter shall clear; end-to-end latency from the raw input change to the o_level change is exactly STABLE_CYCLES+2 edges.
REQ-018 o_press shall be high for exactly the cycle in which o_level goes 0->1; o_release for exactly the cycle in which o_level goes 1->0; never both high together.
REQ-019 Hold counter: clears to 0 while o_level=0; while o_level=1, counts cycles since the press, saturating at LONG_CYCLES+REPEAT_CYCLES.
REQ-020 o_long shall pulse once, in the cycle where the hold counter first equals LONG_CYCLES; at most one o_long per press.
REQ-021 If i_repeat_en[ch]=1, o_press shall additionally pulse at hold counts LONG_CYCLES+k*REPEAT_CYCLES, k>=1, for as long as the key stays held (the hold counter reloads to LONG_CYCLES after each tick).
REQ-022 i_repeat_en is sampled each cycle; deasserting it mid-hold suppresses further repeat ticks without affecting o_level or o_long.
REQ-023 A release accepted in the same cycle a repeat or long tick would fire: o_release wins; o_press and o_long stay low.
REQ-024 Counter widths shall be $clog2 of the largest value held +1; no counter shall wrap.

Reset
REQ-025 While rst_n=0 at a rising edge: o_level, o_press, o_release and o_long = 0; all counters = 0; synchroniser flops = the idle raw level (1 if ACTIVE_LOW else 0).
REQ-026 Reset asserted mid-debounce or mid-hold shall abort all in-progress counts; after release, a key still held shall need a full STABLE_CYCLES+2 before o_press fires.
REQ-027 Outputs shall be valid on the first edge after rst_n returns to 1; no spurious o_press or o_release shall occur at reset exit with keys idle.

Verification (N_CH=4, STABLE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, ACTIVE_LOW=1)
REQ-028 i_key[0] 1->0, held 40 cycles -> o_press[0] at edge 6; o_level[0]=1 from edge 6; o_long[0] 20 cycles later; no repeat ticks while i_repeat_en=0.
REQ-029 i_key[1] 0-pulses of 3 cycles, repeated with 1-cycle gaps -> o_level[1] stays 0, no pulses.
REQ-030 i_repeat_en[2]=1, key held 45 cycles after acceptance -> o_press[2] at hold counts 0, 25, 30, 35, 40; exactly one o_long.
REQ-031 Key released at hold count 25 with repeat enabled -> o_release fires, no o_press that cycle; o_level returns to 0.
REQ-032 rst_n pulsed low mid-hold with the key still pressed -> all outputs 0; o_press fires 6 edges after rst_n rises.
REQ-033 All 4 channels pressed on staggered cycles -> pulses are per-channel and independent, with no cross-channel effects.
